bit_serial_shift_ctrl: RTL and testbench



---
 rtl/bit_serial_shift_ctrl_pkg.sv | 27 ++
 rtl/bit_serial_shift_ctrl_if.sv | 46 ++++
 rtl/bit_serial_shift_ctrl_mux.sv | 13 +
 rtl/bit_serial_shift_ctrl.sv | 135 +++++++++++++
 tb/tb_bit_serial_shift_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bit_serial_shift_ctrl_pkg.sv
// Shared types and constants for the bit-serial shift controller.
// Holds the FSM state encoding, datapath widths and the select-step helper.
package bit_serial_shift_ctrl_pkg;

  localparam int DATA_W = 64;
  localparam int SEL_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Next mux select: down for MSB-first, up for LSB-first.
  // Wraps at 6 bits; the beat counter, not the select,
  // decides when the word ends.
  function automatic logic [SEL_W-1:0] step_sel(
    input logic [SEL_W-1:0] sel,
    input logic             msb_first
  );
    if (msb_first)
      step_sel = sel - SEL_W'(1);
    else
      step_sel = sel + SEL_W'(1);
  endfunction

endpackage

// File: rtl/bit_serial_shift_ctrl_if.sv
// Load and serial-stream bundle for bit_serial_shift_ctrl.
// slave: controller side; master: producer/consumer side.
interface bit_serial_shift_ctrl_if;
  import bit_serial_shift_ctrl_pkg::*;

  logic              load_valid;
  logic              load_ready;
  logic [DATA_W-1:0] load_data;
  logic [SEL_W-1:0]  load_len;
  logic              load_msb_first;
  logic              ser_valid;
  logic              ser_ready;
  logic              ser_bit;
  logic              ser_last;
  logic              busy;
  logic              done;

  modport slave (
    input  load_valid,
    output load_ready,
    input  load_data,
    input  load_len,
    input  load_msb_first,
    output ser_valid,
    input  ser_ready,
    output ser_bit,
    output ser_last,
    output busy,
    output done
  );

  modport master (
    output load_valid,
    input  load_ready,
    output load_data,
    output load_len,
    output load_msb_first,
    input  ser_valid,
    output ser_ready,
    input  ser_bit,
    input  ser_last,
    input  busy,
    input  done
  );

endinterface

// File: rtl/bit_serial_shift_ctrl_mux.sv
// 64-to-1 single-bit multiplexer.
// Ports: data_i word, sel_i bit index, bit_o selected bit.
module Mux64to1
  import bit_serial_shift_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic [SEL_W-1:0]  sel_i,
  output logic              bit_o
);

  assign bit_o = data_i[sel_i];

endmodule

// File: rtl/bit_serial_shift_ctrl.sv
// Serializes a 64-bit word LSB- or MSB-first over a valid/ready stream.
// Ports: clock, reset_n (async, active-low), bus (slave modport).
// Build option SERIAL_PARITY_EN appends an even-parity beat.
module bit_serial_shift_ctrl
  import bit_serial_shift_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  bit_serial_shift_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  len_q, len_d;
  logic              dir_q, dir_d;
  logic              mux_bit;
  logic              data_end;
`ifdef SERIAL_PARITY_EN
  logic              par_q, par_d;
  logic              pbeat_q, pbeat_d;
`endif

  Mux64to1 u_mux (
    .data_i (data_q),
    .sel_i  (sel_q),
    .bit_o  (mux_bit)
  );

  assign data_end = (cnt_q == len_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      dir_q   <= 1'b0;
`ifdef SERIAL_PARITY_EN
      par_q   <= 1'b0;
      pbeat_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
`ifdef SERIAL_PARITY_EN
      par_q   <= par_d;
      pbeat_q <= pbeat_d;
`endif
    end
  end

  always_comb begin
    state_d        = state_q;
    data_d         = data_q;
    sel_d          = sel_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    dir_d          = dir_q;
`ifdef SERIAL_PARITY_EN
    par_d          = par_q;
    pbeat_d        = pbeat_q;
`endif
    bus.load_ready = 1'b0;
    bus.ser_valid  = 1'b0;
    bus.ser_bit    = 1'b0;
    bus.ser_last   = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;

    unique case (1'b1)
      (state_q == IDLE): begin
        bus.load_ready = 1'b1;
        if (bus.load_valid) begin
          data_d  = bus.load_data;
          len_d   = bus.load_len;
          dir_d   = bus.load_msb_first;
          cnt_d   = '0;
          sel_d   = bus.load_msb_first ? bus.load_len : '0;
`ifdef SERIAL_PARITY_EN
          par_d   = 1'b0;
          pbeat_d = 1'b0;
`endif
          state_d = SHIFT;
        end
      end

      (state_q == SHIFT): begin
        bus.ser_valid = 1'b1;
        bus.busy      = 1'b1;
`ifdef SERIAL_PARITY_EN
        // Parity beat follows the last data beat.
        bus.ser_bit  = pbeat_q ? par_q : mux_bit;
        bus.ser_last = pbeat_q;
        if (bus.ser_ready) begin
          if (pbeat_q) begin
            state_d = DONE;
          end else begin
            par_d = par_q ^ mux_bit;
            cnt_d = cnt_q + SEL_W'(1);
            sel_d = step_sel(sel_q, dir_q);
            if (data_end)
              pbeat_d = 1'b1;
          end
        end
`else
        bus.ser_bit  = mux_bit;
        bus.ser_last = data_end;
        if (bus.ser_ready) begin
          cnt_d = cnt_q + SEL_W'(1);
          sel_d = step_sel(sel_q, dir_q);
          if (data_end)
            state_d = DONE;
        end
`endif
      end

      (state_q == DONE): begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bit_serial_shift_ctrl.sv
// Testbench for bit_serial_shift_ctrl: directed table plus random words.
// Honours SERIAL_PARITY_EN to expect the extra parity beat.
module tb_bit_serial_shift_ctrl;
  import bit_serial_shift_ctrl_pkg::*;

`ifdef SERIAL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  bit_serial_shift_ctrl_if bus ();

  bit_serial_shift_ctrl dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;
  bit exp_q[$];

  typedef struct {
    string       name;
    logic [63:0] d;
    int          len;
    bit          msb;
    int          mode;
    bit          inj;
    logic [64:0] exp;
    int          beats;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask

  // Reference: the word's bits in stream order, then parity.
  function automatic void build_model(input logic [63:0] d,
                                      input int len,
                                      input bit msb);
    bit p = 1'b0;
    exp_q.delete();
    for (int k = 0; k <= len; k++) begin
      int idx = msb ? (len - k) : k;
      exp_q.push_back(d[idx]);
      p ^= d[idx];
    end
    if (PAR == 1) exp_q.push_back(p);
  endfunction

  // Called at a negedge while the DUT is idle; returns at the
  // negedge of the first idle cycle after the word finishes.
  // mode 0: always ready, 1: random ready, 2: stall 3 cycles at beat 2.
  task automatic run_word(input string tag,
                          input logic [63:0] d,
                          input int len,
                          input bit msb,
                          input int mode,
                          input bit inj);
    int   i = 0;
    int   cyc = 0;
    int   stall = 0;
    bit   held = 1'b0;
    bit   rdy;
    logic hb, hl;
    check({tag, " load_ready idle"}, 64'(bus.load_ready), 64'd1);
    bus.load_valid     = 1'b1;
    bus.load_data      = d;
    bus.load_len       = 6'(len);
    bus.load_msb_first = msb;
    @(negedge clock);
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    while (i < exp_q.size() && cyc < 1000) begin
      check({tag, " ser_valid"}, 64'(bus.ser_valid), 64'd1);
      check({tag, " busy"}, 64'(bus.busy), 64'd1);
      check({tag, " load_ready shift"}, 64'(bus.load_ready), 64'd0);
      if (held) begin
        check({tag, " hold bit"}, 64'(bus.ser_bit), 64'(hb));
        check({tag, " hold last"}, 64'(bus.ser_last), 64'(hl));
      end
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = ($urandom_range(0, 9) < 7);
      else rdy = !(i == 2 && stall < 3);
      if (mode == 2 && i == 2 && stall < 3) stall++;
      if (rdy) begin
        check($sformatf("%s bit%0d", tag, i), 64'(bus.ser_bit), 64'(exp_q[i]));
        check($sformatf("%s last%0d", tag, i), 64'(bus.ser_last),
              64'(i == exp_q.size() - 1));
        i++;
        held = 1'b0;
      end else begin
        held = 1'b1;
        hb = bus.ser_bit;
        hl = bus.ser_last;
      end
      bus.ser_ready  = rdy;
      bus.load_valid = inj && (i == 1);
      bus.load_data  = 64'hFF;
      @(negedge clock);
      cyc++;
    end
    bus.ser_ready  = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    check({tag, " beats"}, 64'(i), 64'(exp_q.size()));
    check({tag, " done pulse"}, 64'(bus.done), 64'd1);
    check({tag, " no extra beat"}, 64'(bus.ser_valid), 64'd0);
    check({tag, " load_ready done"}, 64'(bus.load_ready), 64'd0);
    @(negedge clock);
    check({tag, " done cleared"}, 64'(bus.done), 64'd0);
    check({tag, " load_ready back"}, 64'(bus.load_ready), 64'd1);
  endtask

  initial begin
    tbl[0] = '{"lsb5", 64'h5, 3, 1'b0, 0, 1'b0, 65'h5, 4 + PAR};
    tbl[1] = '{"msb5", 64'h5, 3, 1'b1, 0, 1'b0, 65'hA, 4 + PAR};
    tbl[2] = '{"stallA5", 64'hA5, 7, 1'b0, 2, 1'b0, 65'hA5, 8 + PAR};
    tbl[3] = '{"len63", 64'h8000_0000_0000_0001, 63, 1'b0, 0, 1'b0,
               65'h0_8000_0000_0000_0001, 64 + PAR};
    tbl[4] = '{"inject", 64'h3C, 5, 1'b0, 1, 1'b1, 65'h3C, 6 + PAR};
    tbl[5] = '{"par7", 64'h7, 3, 1'b0, 0, 1'b0,
               (PAR == 1) ? 65'h17 : 65'h7, 4 + PAR};

    bus.load_valid     = 1'b0;
    bus.load_data      = '0;
    bus.load_len       = '0;
    bus.load_msb_first = 1'b0;
    bus.ser_ready      = 1'b0;
    repeat (2) @(negedge clock);
    check("rst load_ready", 64'(bus.load_ready), 64'd1);
    check("rst ser_valid", 64'(bus.ser_valid), 64'd0);
    check("rst ser_bit", 64'(bus.ser_bit), 64'd0);
    check("rst ser_last", 64'(bus.ser_last), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst done", 64'(bus.done), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Directed vectors, back-to-back.
    for (int k = 0; k < 6; k++) begin
      exp_q.delete();
      for (int b = 0; b < tbl[k].beats; b++)
        exp_q.push_back(tbl[k].exp[b]);
      run_word(tbl[k].name, tbl[k].d, tbl[k].len, tbl[k].msb,
               tbl[k].mode, tbl[k].inj);
    end

    // Reset in the middle of a word.
    check("mid load_ready", 64'(bus.load_ready), 64'd1);
    bus.load_valid = 1'b1;
    bus.load_data  = 64'hA5;
    bus.load_len   = 6'd7;
    bus.load_msb_first = 1'b0;
    @(negedge clock);
    bus.load_valid = 1'b0;
    bus.ser_ready  = 1'b1;
    repeat (2) @(negedge clock);
    check("mid bit2 valid", 64'(bus.ser_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async ser_valid", 64'(bus.ser_valid), 64'd0);
    check("async busy", 64'(bus.busy), 64'd0);
    check("async load_ready", 64'(bus.load_ready), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    bus.ser_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("post rst no done", 64'(bus.done), 64'd0);
      check("post rst idle", 64'(bus.ser_valid), 64'd0);
    end
    build_model(64'hA5, 7, 1'b0);
    run_word("after_rst", 64'hA5, 7, 1'b0, 0, 1'b0);

    // Random words with random consumer back-pressure.
    for (int r = 0; r < 30; r++) begin
      logic [63:0] d;
      int len;
      bit msb;
      d = {$urandom(), $urandom()};
      len = $urandom_range(0, 63);
      msb = 1'($urandom_range(0, 1));
      build_model(d, len, msb);
      run_word($sformatf("rnd%0d", r), d, len, msb, 1, r[0]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
